// File: rtl/board_level_stream_pkg.sv
// Shared definitions for the board-level stream receiver.
//
// Contents:
//   state_t          receiver FSM states (ST_IDLE, ST_RECV)
//   ENT_*            bit offsets of the control fields in a FIFO entry.
//                    The entry is {sof, eof, error, data[DATA_W-1:0]}.
//                    Each control offset is added to DATA_W.
//   CRC8_POLY/INIT   CRC-8/MAXIM constants (reflected form, no xorout)
//   crc8_maxim_byte  folds one byte into a running CRC-8/MAXIM value
package board_level_stream_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam int ENT_ERR_OFS = 0;
  localparam int ENT_EOF_OFS = 1;
  localparam int ENT_SOF_OFS = 2;
  localparam int ENT_CTRL_W  = 3;

  localparam logic [7:0] CRC8_POLY = 8'h8C;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Reflected CRC: the byte is consumed LSB first.
  function automatic logic [7:0] crc8_maxim_byte(input logic [7:0] last_crc,
                                                 input logic [7:0] data);
    logic [7:0] c;
    c = last_crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC8_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/board_level_stream_fifo.sv
// Synchronous show-ahead FIFO. The head entry is visible on rd_data whenever
// empty is low. It accepts one write and one read per cycle. A write while
// full succeeds only if a read happens in the same cycle.
//
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 4)
// Ports:
//   clk, rst       clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data write request and entry
//   rd_en          pop the head (ignored while empty)
//   rd_data        head entry
//   full, empty    occupancy flags
module board_level_stream_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_rd;
  logic             do_wr;

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/board_level_stream_receiver.sv
// Frame receiver. It repacks SYM_W-bit symbols (MSB first) into DATA_W-bit
// words with a bit-accurate gearbox. Start, data and end beats go into an
// output FIFO with a valid/ready handshake.
//
// Optional feature: define BOARD_LEVEL_STREAM_RECEIVER_CRC_EN to enable it.
// The last complete word of each frame is then treated as a CRC-8/MAXIM of
// the preceding words and is not output. A mismatch, or a frame with no
// complete word, sets the error flag on the end beat. DATA_W must be 8 with
// this feature enabled.
//
// Parameters: SYM_W (1..DATA_W), DATA_W, FIFO_DEPTH (power of two, >= 4)
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   sym_valid             symbol or marker present
//   sym_start, sym_end    frame markers (start wins over end)
//   sym_data              symbol
//   out_valid, out_ready  output handshake
//   out_data              word (0 on start/end beats and when not valid)
//   out_sof, out_eof      head is a start / end beat
//   out_error             frame error, meaningful with out_eof
//   overflow              sticky: a beat was dropped on a full FIFO
//   aborted               one-cycle pulse when a start interrupts an open frame
module board_level_stream_receiver
  import board_level_stream_pkg::*;
#(
  parameter int SYM_W      = 6,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid,
  input  logic              sym_start,
  input  logic              sym_end,
  input  logic [SYM_W-1:0]  sym_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_error,
  output logic              overflow,
  output logic              aborted
);

  // The accumulator holds fewer than DATA_W bits before a symbol is added.
  // So SYM_W + DATA_W - 1 bits is always enough.
  localparam int ACC_W = SYM_W + DATA_W - 1;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int ENT_W = DATA_W + ENT_CTRL_W;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;

  logic [ACC_W-1:0]  acc_app;
  logic [CNT_W-1:0]  cnt_app;
  logic [CNT_W-1:0]  cnt_rem;
  logic              word_rdy;
  logic [DATA_W-1:0] word;

  logic              is_start;
  logic              is_end;
  logic              is_data;
  logic              word_take;
  logic              crc_fail;

  logic              push_vld_p0;
  logic              push_sof_p0;
  logic              push_eof_p0;
  logic              push_err_p0;
  logic [DATA_W-1:0] push_data_p0;
  logic              abort_p0;

  logic              drop_flag;
  logic              drop;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ENT_W-1:0]  entry;
  logic [ENT_W-1:0]  head;

`ifdef BOARD_LEVEL_STREAM_RECEIVER_CRC_EN
  logic [DATA_W-1:0] held;
  logic              have_held;
  logic [7:0]        crc;
`endif

  assign is_start  = sym_valid & sym_start;
  assign is_end    = sym_valid & ~sym_start & sym_end & (state == ST_RECV);
  assign is_data   = sym_valid & ~sym_start & ~sym_end & (state == ST_RECV);
  assign word_take = is_data & word_rdy;

  // The new symbol goes into the low end. The word is the oldest DATA_W
  // valid bits, which sit just below bit position cnt_app.
  always_comb begin
    acc_app  = (acc << SYM_W) | ACC_W'(sym_data);
    cnt_app  = cnt + CNT_W'(SYM_W);
    word_rdy = (cnt_app >= CNT_W'(DATA_W));
    word     = DATA_W'(acc_app >> (cnt_app - CNT_W'(DATA_W)));
    cnt_rem  = word_rdy ? (cnt_app - CNT_W'(DATA_W)) : cnt_app;
  end

`ifdef BOARD_LEVEL_STREAM_RECEIVER_CRC_EN
  // At end, the held word is the received CRC. The running CRC covers every
  // word before it.
  assign crc_fail = ~have_held | (held != crc);
`else
  assign crc_fail = 1'b0;
`endif

  // ---- Stage p0: frame FSM, gearbox, and beat formation ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      push_vld_p0 <= 1'b0;
      push_sof_p0 <= 1'b0;
      push_eof_p0 <= 1'b0;
      push_err_p0 <= 1'b0;
      abort_p0    <= 1'b0;
`ifdef BOARD_LEVEL_STREAM_RECEIVER_CRC_EN
      have_held   <= 1'b0;
`endif
    end else begin
      abort_p0    <= is_start & (state == ST_RECV);
      push_sof_p0 <= is_start;
      push_eof_p0 <= is_end;
      push_err_p0 <= is_end & crc_fail;
`ifdef BOARD_LEVEL_STREAM_RECEIVER_CRC_EN
      // Each new word releases the previously held one.
      push_vld_p0 <= is_start | is_end | (word_take & have_held);
      if (is_start)       have_held <= 1'b0;
      else if (word_take) have_held <= 1'b1;
`else
      push_vld_p0 <= is_start | is_end | word_take;
`endif
      // A start in RECV drops the open frame silently.
      if (is_start) begin
        state <= ST_RECV;
        cnt   <= '0;
      end else if (is_end) begin
        state <= ST_IDLE;
      end else if (is_data) begin
        cnt   <= cnt_rem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (is_data) acc <= acc_app;
`ifdef BOARD_LEVEL_STREAM_RECEIVER_CRC_EN
    if (is_start | is_end) push_data_p0 <= '0;
    else if (word_take)    push_data_p0 <= held;
    if (is_start)                  crc <= CRC8_INIT;
    else if (word_take & have_held) crc <= crc8_maxim_byte(crc, held);
    if (word_take) held <= word;
`else
    if (is_start | is_end) push_data_p0 <= '0;
    else if (word_take)    push_data_p0 <= word;
`endif
  end

  // ---- Stage p1: FIFO write, drop detection, and flag outputs ----
  assign pop  = ~empty & out_ready;
  assign drop = push_vld_p0 & full & ~pop;

  // Earlier beats of this frame were already written, so drop_flag is
  // up to date when the end beat gets its error bit.
  always_comb begin
    entry                        = '0;
    entry[DATA_W-1:0]            = push_data_p0;
    entry[DATA_W + ENT_SOF_OFS]  = push_sof_p0;
    entry[DATA_W + ENT_EOF_OFS]  = push_eof_p0;
    entry[DATA_W + ENT_ERR_OFS]  = push_eof_p0 & (push_err_p0 | drop_flag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      drop_flag <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      aborted <= abort_p0;
      if (drop) overflow <= 1'b1;
      // A start beat opens a new frame. It is clean unless the start beat
      // itself is dropped.
      if (push_vld_p0 & push_sof_p0) drop_flag <= drop;
      else if (drop)                 drop_flag <= 1'b1;
    end
  end

  board_level_stream_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_vld_p0),
    .wr_data (entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Outputs read as zero while the FIFO is empty, including after reset.
  assign out_valid = ~empty;
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_sof   = out_valid & head[DATA_W + ENT_SOF_OFS];
  assign out_eof   = out_valid & head[DATA_W + ENT_EOF_OFS];
  assign out_error = out_valid & head[DATA_W + ENT_ERR_OFS];

endmodule

// File: tb/tb_board_level_stream_receiver.sv
// Directed bench for board_level_stream_receiver (SYM_W=6, DATA_W=8,
// FIFO_DEPTH=4). Expected beats are {sof, eof, error, data[7:0]}: start beats
// are 11'h400, clean end beats are 11'h200, and failed end beats are 11'h300.
// Expectations depend on whether BOARD_LEVEL_STREAM_RECEIVER_CRC_EN is defined.
module tb_board_level_stream_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic       sym_start = 1'b0;
  logic       sym_end = 1'b0;
  logic [5:0] sym_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       out_error;
  logic       overflow;
  logic       aborted;

  int checks = 0;
  int errors = 0;
  int abort_cnt = 0;

  logic [10:0] got [32];
  int          got_n;

  always #5 clk = ~clk;

  board_level_stream_receiver #(
    .SYM_W      (6),
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym_start (sym_start),
    .sym_end   (sym_end),
    .sym_data  (sym_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_error (out_error),
    .overflow  (overflow),
    .aborted   (aborted)
  );

  always @(negedge clk) if (aborted === 1'b1) abort_cnt++;

  task automatic drive(input bit s, input bit e, input logic [5:0] d);
    @(negedge clk);
    sym_valid = 1'b1;
    sym_start = s;
    sym_end   = e;
    sym_data  = d;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sym_valid = 1'b0;
      sym_start = 1'b0;
      sym_end   = 1'b0;
      sym_data  = '0;
    end
  endtask

  // Pops up to n beats, bounded by a cycle budget. rnd toggles out_ready randomly.
  task automatic collect(input int n, input bit rnd);
    got_n = 0;
    for (int c = 0; c < 300 && got_n < n; c++) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        got[got_n] = {out_sof, out_eof, out_error, out_data};
        got_n++;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 7;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset out_data got %h exp 00", out_data); end
    if (out_sof !== 1'b0)   begin errors++; $display("FAIL reset out_sof got %b exp 0", out_sof); end
    if (out_eof !== 1'b0)   begin errors++; $display("FAIL reset out_eof got %b exp 0", out_eof); end
    if (out_error !== 1'b0) begin errors++; $display("FAIL reset out_error got %b exp 0", out_error); end
    if (overflow !== 1'b0)  begin errors++; $display("FAIL reset overflow got %b exp 0", overflow); end
    if (aborted !== 1'b0)   begin errors++; $display("FAIL reset aborted got %b exp 0", aborted); end
    rst = 1'b0;
  endtask

  task automatic test_idle_ignore;
    drive(0, 0, 6'h15);
    drive(0, 1, 6'h00);
    drive(0, 0, 6'h3F);
    drive_idle(5);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_basic;
    logic [10:0] exp [$];
    int a0;
`ifdef BOARD_LEVEL_STREAM_RECEIVER_CRC_EN
    exp = '{11'h400, 11'h001, 11'h200};
`else
    exp = '{11'h400, 11'h001, 11'h05E, 11'h200};
`endif
    a0 = abort_cnt;
    fork
      begin
        drive(1, 0, 6'h00); drive(0, 0, 6'h00); drive(0, 0, 6'h15);
        drive(0, 0, 6'h38); drive(0, 1, 6'h00); drive_idle(1);
      end
      collect(exp.size(), 1'b0);
    join
    checks++;
    if (got_n !== exp.size()) begin errors++; $display("FAIL basic count got %0d exp %0d", got_n, exp.size()); end
    for (int i = 0; i < exp.size() && i < got_n; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL basic beat%0d got %h exp %h", i, got[i], exp[i]); end
    end
    checks++;
    if (abort_cnt !== a0) begin errors++; $display("FAIL basic aborted pulses got %0d exp 0", abort_cnt - a0); end
  endtask

  // Back-to-back frames: bad CRC word, pad bit change only, empty frame.
  task automatic test_crc_variants;
    logic [10:0] exp [$];
`ifdef BOARD_LEVEL_STREAM_RECEIVER_CRC_EN
    exp = '{11'h400, 11'h001, 11'h300, 11'h400, 11'h001, 11'h200, 11'h400, 11'h300};
`else
    exp = '{11'h400, 11'h001, 11'h05A, 11'h200, 11'h400, 11'h001, 11'h05E, 11'h200,
            11'h400, 11'h200};
`endif
    fork
      begin
        drive(1, 0, 6'h00); drive(0, 0, 6'h00); drive(0, 0, 6'h15); drive(0, 0, 6'h28); drive(0, 1, 6'h00);
        drive(1, 0, 6'h00); drive(0, 0, 6'h00); drive(0, 0, 6'h15); drive(0, 0, 6'h39); drive(0, 1, 6'h00);
        drive(1, 0, 6'h00); drive(0, 1, 6'h00);
        drive_idle(1);
      end
      collect(exp.size(), 1'b0);
    join
    checks++;
    if (got_n !== exp.size()) begin errors++; $display("FAIL crc_variants count got %0d exp %0d", got_n, exp.size()); end
    for (int i = 0; i < exp.size() && i < got_n; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL crc_variants beat%0d got %h exp %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_abort;
    logic [10:0] exp [$];
    int a0;
`ifdef BOARD_LEVEL_STREAM_RECEIVER_CRC_EN
    exp = '{11'h400, 11'h400, 11'h001, 11'h200};
`else
    exp = '{11'h400, 11'h001, 11'h400, 11'h001, 11'h05E, 11'h200};
`endif
    a0 = abort_cnt;
    fork
      begin
        drive(1, 0, 6'h00); drive(0, 0, 6'h00); drive(0, 0, 6'h15);
        drive(1, 0, 6'h00); drive(0, 0, 6'h00); drive(0, 0, 6'h15); drive(0, 0, 6'h38);
        drive(0, 1, 6'h00); drive_idle(3);
      end
      collect(exp.size(), 1'b0);
    join
    checks++;
    if (got_n !== exp.size()) begin errors++; $display("FAIL abort count got %0d exp %0d", got_n, exp.size()); end
    for (int i = 0; i < exp.size() && i < got_n; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL abort beat%0d got %h exp %h", i, got[i], exp[i]); end
    end
    checks++;
    if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL abort pulses got %0d exp 1", abort_cnt - a0); end
  endtask

  // Symbols 1..8 form words 04 20 C4 14 61 C8. Only the start beat and the
  // first three words fit in the 4-entry FIFO.
  task automatic test_overflow;
    logic [10:0] exp [$];
    logic [7:0]  d0;
    exp = '{11'h400, 11'h004, 11'h020, 11'h0C4};
    @(negedge clk);
    out_ready = 1'b0;
    drive(1, 0, 6'h00);
    for (int s = 1; s <= 8; s++) drive(0, 0, 6'(s));
    drive_idle(3);
    d0 = {out_sof, out_eof, out_error, out_data[4:0]};
    checks += 3;
    if (overflow !== 1'b1)  begin errors++; $display("FAIL overflow flag got %b exp 1", overflow); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL overflow head_valid got %b exp 1", out_valid); end
    if (out_sof !== 1'b1)   begin errors++; $display("FAIL overflow head_sof got %b exp 1", out_sof); end
    drive_idle(2);
    checks++;
    if ({out_sof, out_eof, out_error, out_data[4:0]} !== d0)
      begin errors++; $display("FAIL overflow head_stable got %h exp %h", {out_sof, out_eof, out_error, out_data[4:0]}, d0); end
    collect(exp.size(), 1'b0);
    checks++;
    if (got_n !== exp.size()) begin errors++; $display("FAIL overflow count got %0d exp %0d", got_n, exp.size()); end
    for (int i = 0; i < exp.size() && i < got_n; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL overflow beat%0d got %h exp %h", i, got[i], exp[i]); end
    end
    drive_idle(3);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL overflow drained got %b exp 0", out_valid); end
    fork
      begin drive(0, 1, 6'h00); drive_idle(1); end
      collect(1, 1'b0);
    join
    checks += 3;
    if (got_n !== 1) begin errors++; $display("FAIL overflow end_count got %0d exp 1", got_n); end
    if (got[0] !== 11'h300) begin errors++; $display("FAIL overflow end_beat got %h exp 300", got[0]); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow sticky got %b exp 1", overflow); end
  endtask

  task automatic test_reset_mid_frame;
    logic [10:0] exp [$];
`ifdef BOARD_LEVEL_STREAM_RECEIVER_CRC_EN
    exp = '{11'h400, 11'h001, 11'h200};
`else
    exp = '{11'h400, 11'h001, 11'h05E, 11'h200};
`endif
    @(negedge clk);
    out_ready = 1'b0;
    drive(1, 0, 6'h00); drive(0, 0, 6'h00); drive(0, 0, 6'h15);
    drive_idle(3);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid pre_valid got %b exp 1", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got %b exp 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL rst_mid out_data got %h exp 00", out_data); end
    if (out_sof !== 1'b0)   begin errors++; $display("FAIL rst_mid out_sof got %b exp 0", out_sof); end
    if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_mid overflow got %b exp 0", overflow); end
    if (aborted !== 1'b0)   begin errors++; $display("FAIL rst_mid aborted got %b exp 0", aborted); end
    // The receiver is back in IDLE, so the rest of the old frame is ignored.
    drive(0, 0, 6'h38); drive(0, 1, 6'h00);
    drive_idle(4);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid no_end_beat got %b exp 0", out_valid); end
    fork
      begin
        drive(1, 0, 6'h00); drive(0, 0, 6'h00); drive(0, 0, 6'h15);
        drive(0, 0, 6'h38); drive(0, 1, 6'h00); drive_idle(1);
      end
      collect(exp.size(), 1'b0);
    join
    checks++;
    if (got_n !== exp.size()) begin errors++; $display("FAIL rst_mid count got %0d exp %0d", got_n, exp.size()); end
    for (int i = 0; i < exp.size() && i < got_n; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL rst_mid beat%0d got %h exp %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_random_ready;
    logic [10:0] exp [$];
`ifdef BOARD_LEVEL_STREAM_RECEIVER_CRC_EN
    exp = '{11'h400, 11'h001, 11'h200};
`else
    exp = '{11'h400, 11'h001, 11'h05E, 11'h200};
`endif
    for (int f = 0; f < 3; f++) begin
      fork
        begin
          drive(1, 0, 6'h00); drive(0, 0, 6'h00); drive(0, 0, 6'h15);
          drive(0, 0, 6'h38); drive(0, 1, 6'h00); drive_idle(1);
        end
        collect(exp.size(), 1'b1);
      join
      checks++;
      if (got_n !== exp.size()) begin errors++; $display("FAIL random_ready f%0d count got %0d exp %0d", f, got_n, exp.size()); end
      for (int i = 0; i < exp.size() && i < got_n; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin errors++; $display("FAIL random_ready f%0d beat%0d got %h exp %h", f, i, got[i], exp[i]); end
      end
      @(negedge clk);
      out_ready = 1'b1;
      drive_idle(2);
    end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL random_ready overflow got %b exp 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_crc_variants();
    test_abort();
    test_overflow();
    test_reset_mid_frame();
    test_random_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_level_stream_receiver.md
# board_level_stream_receiver

Parametrised frame receiver. It takes SYM_W-bit symbols and frame markers from the physical receive layer and repacks them into DATA_W-bit words with a bit-accurate gearbox. It optionally checks a trailing CRC-8/MAXIM byte and buffers the output in a FIFO with a valid/ready handshake. It replaces the fixed 6→8-bit receiver and adds backpressure, overflow detection and abort reporting.

## Interface
- SYM_W, 6, symbol width from the physical layer; 1 ≤ SYM_W ≤ DATA_W
- DATA_W, 8, output word width; must be 8 when CRC is compiled in
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥ 4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sym_valid  in  1  symbol/marker present this cycle
- sym_start  in  1  frame-start marker (qualified by sym_valid); sym_data ignored
- sym_end  in  1  frame-end marker (qualified by sym_valid); sym_data ignored; start has priority over end
- sym_data  in  SYM_W  symbol, MSB first on the wire
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  DATA_W  word; 0 on start/end beats
- out_sof  out  1  head is a start beat
- out_eof  out  1  head is an end beat
- out_error  out  1  frame error, meaningful only with out_eof
- overflow  out  1  sticky: a beat was dropped because the FIFO was full
- aborted  out  1  one-cycle pulse: start received while a frame was open

## Operation
- States: IDLE, RECV. Reset → IDLE.
- IDLE: start → reset gearbox/CRC/hold/drop flag, push start beat, → RECV. Data symbols and end are ignored.
- RECV:
  - Data symbol: appended to the accumulator. An accumulator of width SYM_W+DATA_W-1 is sufficient.
  - When bit count ≥ DATA_W: top DATA_W bits form a word; count -= DATA_W. At most one word per symbol.
  - Word handling depends on the CRC configuration (see below).
- End (RECV): residual bits (< DATA_W) are discarded. An end beat is pushed with error = crc_fail | drop_flag. State → IDLE.
- Start (RECV): aborted pulses. The open frame is discarded without an end beat. Processing then proceeds exactly as start in IDLE.
- FIFO entry: {sof, eof, error, data}. Pop when out_valid & out_ready.
- Push while full: the entry is dropped, overflow is set, and drop_flag is set for the current frame. A dropped end beat is simply lost.
- Simultaneous push and pop when full: the pop frees space and the push succeeds.
- rst mid-frame: everything cleared, FIFO emptied, no end beat.

## Timing
- Reset values: out_valid 0, out_data 0, out_sof 0, out_eof 0, out_error 0, overflow 0, aborted 0.
- Input sampled at edge E. The resulting beat is written at edge E+1. With an empty FIFO, out_valid is high in the cycle after E+1 (2-cycle latency).
- With CRC compiled in, a data word additionally waits in the hold register until the next word or end arrives.
- aborted is high for the cycle after edge E+1.
- The FIFO sustains 1 push + 1 pop per cycle. out_* are stable while out_valid & !out_ready.
- overflow is cleared only by rst.

## Configuration
- BOARD_LEVEL_STREAM_RECEIVER_CRC_EN defined:
  - The last complete word of a frame is the CRC and is never output. Each new word pushes the previous held word and updates the CRC with it.
  - CRC-8/MAXIM: reflected poly 0x8C, init 0x00, no xorout.
  - At end: crc_fail = (held ≠ crc) | (no word received).
- Undefined: every word is pushed immediately, crc_fail = 0, and no hold register or CRC logic is synthesised.

## Structure
- Package board_level_stream_pkg holds:
  - the FSM state enum;
  - the FIFO entry field offsets;
  - the CRC constants 0x8C and 0x00;
  - the function crc8_maxim_byte(last_crc, data).
- Sub-module board_level_stream_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH and full/empty outputs.

## Test plan
- CRC on, SYM_W=6, out_ready=1: start, symbols 0x00, 0x15, 0x38, end → start beat; data 0x01; end beat with error=0. Residual 2 bits are discarded.
- Same frame with third symbol 0x28 (CRC word becomes 0x5A) → data 0x01; end beat error=1. Then start, 0x00, 0x15, 0x39, end → error=0, because only the discarded pad bit changed.
- out_ready=0, FIFO_DEPTH=4: start plus 6 words → overflow=1; later end beat error=1; entries are delivered in order once ready.
- Start, 0x00, 0x15, start, 0x00, 0x15, 0x38, end → aborted pulse once. Output is: start; start; 0x01; end error=0. There is no end beat for the first frame.
- Data symbols and end while IDLE → no beats pushed. rst asserted mid-frame → all outputs return to reset values next cycle.
- CRC off, SYM_W=8: start, 0xA5, 0x3C, end → data 0xA5, 0x3C; end error=0. Random out_ready toggling yields an identical sequence.
